array_swap_engine: RTL

ARRAY_SWAP_ENGINE -- requirements
Module: array_swap_engine

---
 rtl/EV_types.sv | 4 +
 rtl/array_swap_pkg.sv | 33 +++
 rtl/swap_range_check.sv | 34 +++
 rtl/array_swap_engine.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/EV_types.sv
// Execution-environment sizing constants shared by blocks that address the word store.
package EV_types;
  localparam int EV_Length_u32 = 64;
endpackage

// File: rtl/array_swap_pkg.sv
// Shared types for the array swap/move engine and its range checker.
package array_swap_pkg;
  // Command fields are stored at the widest supported address width and sliced by the engine.
  localparam int MAX_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } swap_state_e;

  typedef enum logic [1:0] {
    STAT_OK          = 2'd0,
    STAT_SKIP        = 2'd1,
    STAT_ERR_RANGE   = 2'd2,
    STAT_ERR_OVERLAP = 2'd3
  } swap_status_e;

  typedef enum logic {
    MODE_SWAP = 1'b0,
    MODE_MOVE = 1'b1
  } swap_mode_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] arr_1;
    logic [MAX_ADDR_W-1:0] arr_2;
    logic [MAX_ADDR_W:0]   length;
    swap_mode_e            mode;
    logic                  cond_ok;
  } swap_cmd_t;
endpackage

// File: rtl/swap_range_check.sv
// Combinational legality check of a latched command: skip, range and overlap, in priority order.
module swap_range_check
  import array_swap_pkg::*;
#(
  parameter int EV_WORDS = 64
) (
  input  logic [MAX_ADDR_W-1:0] arr_1,
  input  logic [MAX_ADDR_W-1:0] arr_2,
  input  logic [MAX_ADDR_W:0]   length,
  input  logic                  cond_ok,
  output swap_status_e          status
);
  // Two spare bits keep base + length from wrapping for any field value.
  localparam int CW = MAX_ADDR_W + 2;

  logic [CW-1:0] a1, a2, len, end_1, end_2, lim;
  logic          range_bad, overlap;

  assign a1        = CW'(arr_1);
  assign a2        = CW'(arr_2);
  assign len       = CW'(length);
  assign end_1     = a1 + len;
  assign end_2     = a2 + len;
  assign lim       = CW'(EV_WORDS);
  assign range_bad = (end_1 > lim) || (end_2 > lim);
  assign overlap   = (len != '0) && (a1 < end_2) && (a2 < end_1);

  always_comb begin
    status = STAT_OK;
    if (!cond_ok)       status = STAT_SKIP;
    else if (range_bad) status = STAT_ERR_RANGE;
    else if (overlap)   status = STAT_ERR_OVERLAP;
  end
endmodule

// File: rtl/array_swap_engine.sv
// Swaps or moves a word range between two arrays, LANES words per port per cycle, with pipelined writes.
module array_swap_engine
  import array_swap_pkg::*;
#(
  parameter int  EV_WORDS = EV_types::EV_Length_u32,
  parameter int  LANES    = 1,
  localparam int ADDR_W   = $clog2(EV_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_arr_1,
  input  logic [ADDR_W-1:0]     cmd_arr_2,
  input  logic [ADDR_W:0]       cmd_length,
  input  logic                  cmd_mode,
  input  logic                  cmd_cond_ok,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr_a,
  output logic [ADDR_W-1:0]     rd_addr_b,
  input  logic [LANES*32-1:0]   rd_data_a,
  input  logic [LANES*32-1:0]   rd_data_b,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic [ADDR_W-1:0]     wr_addr_a,
  output logic [ADDR_W-1:0]     wr_addr_b,
  output logic [LANES*32-1:0]   wr_data_a,
  output logic [LANES*32-1:0]   wr_data_b,
  output logic [LANES-1:0]      wr_mask,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [2:0]            state_dbg
);
  localparam logic [ADDR_W:0]   LANES_W = (ADDR_W+1)'(LANES);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(LANES);

  swap_state_e      state;
  swap_cmd_t        cmd_q;
  swap_status_e     chk_status;
  swap_status_e     status_q;
  logic [ADDR_W:0]  rem;
  logic [LANES-1:0] chunk_mask;
  logic             last_chunk;

  swap_range_check #(.EV_WORDS(EV_WORDS)) u_check (
    .arr_1   (cmd_q.arr_1),
    .arr_2   (cmd_q.arr_2),
    .length  (cmd_q.length),
    .cond_ok (cmd_q.cond_ok),
    .status  (chk_status)
  );

  // rem counts words not yet read; the chunk being read covers min(rem, LANES) words.
  assign last_chunk = (rem <= LANES_W);
  always_comb begin
    chunk_mask = '0;
    for (int i = 0; i < LANES; i++) chunk_mask[i] = (rem > (ADDR_W+1)'(i));
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign status    = status_q;
  // Read data returns one cycle after rd_en, which is exactly the write cycle of that chunk.
  assign wr_data_a = wr_en_a ? rd_data_b : '0;
  assign wr_data_b = wr_en_b ? rd_data_a : '0;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE, fields are latched on that edge and inputs are ignored until IDLE again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      status_q  <= STAT_OK;
      cmd_ready <= 1'b0;
      rem       <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_en_a   <= 1'b0;
      wr_en_b   <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_mask   <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      wr_en_a   <= rd_en && (cmd_q.mode == MODE_SWAP);
      wr_en_b   <= rd_en;
      wr_addr_a <= rd_en ? rd_addr_a : '0;
      wr_addr_b <= rd_en ? rd_addr_b : '0;
      wr_mask   <= rd_en ? chunk_mask : '0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_q.arr_1   <= MAX_ADDR_W'(cmd_arr_1);
            cmd_q.arr_2   <= MAX_ADDR_W'(cmd_arr_2);
            cmd_q.length  <= (MAX_ADDR_W+1)'(cmd_length);
            cmd_q.mode    <= swap_mode_e'(cmd_mode);
            cmd_q.cond_ok <= cmd_cond_ok;
            cmd_ready     <= 1'b0;
            state         <= CHECK;
          end
        end
        CHECK: begin
          status_q <= chk_status;
          if (chk_status == STAT_OK && cmd_q.length != '0) begin
            rd_en     <= 1'b1;
            rd_addr_a <= cmd_q.arr_1[ADDR_W-1:0];
            rd_addr_b <= cmd_q.arr_2[ADDR_W-1:0];
            rem       <= cmd_q.length[ADDR_W:0];
            state     <= RUN;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RUN: begin
          if (last_chunk) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rem       <= rem - LANES_W;
            rd_addr_a <= rd_addr_a + STEP;
            rd_addr_b <= rd_addr_b + STEP;
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
